// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative cache: hit service, dirty-victim writeback, line fill.
// Owns per-set LRU bits; all datapath strobes are decoded from state, hit, dirty and LRU.
module cache_control #(
    parameter int unsigned S_OFFSET = 5,
    parameter int unsigned S_INDEX  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] mem_address_i,
    output logic        mem_resp_o,
    input  logic [1:0]  hit_i,
    input  logic [1:0]  dirty_i,
    input  logic        pmem_resp_i,
    output logic        pmem_read_o,
    output logic        pmem_write_o,
    output logic        pmem_addr_sel_o,
    output logic        way_sel_o,
    output logic        data_src_o,
    output logic [1:0]  load_data_o,
    output logic [1:0]  load_tag_o,
    output logic [1:0]  load_valid_o,
    output logic [1:0]  set_dirty_o,
    output logic [1:0]  clr_dirty_o
);

    localparam int unsigned NUM_SETS = 1 << S_INDEX;
    localparam int unsigned IDX_LSB  = S_OFFSET;
    localparam int unsigned IDX_MSB  = S_OFFSET + S_INDEX - 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;

    logic [S_INDEX-1:0] idx;
    logic               req;
    logic               is_write;
    logic               hit_way;
    logic               victim;
    logic [1:0]         hit_oh;
    logic [1:0]         victim_oh;
    logic               unused_addr_bits;

    assign idx       = mem_address_i[IDX_MSB:IDX_LSB];
    assign req       = mem_read_i | mem_write_i;
    // A simultaneous read and write is served as a write.
    assign is_write  = mem_write_i;
    assign hit_way   = hit_i[0] ? 1'b0 : 1'b1;
    assign victim    = lru_q[idx];
    assign hit_oh    = hit_way ? 2'b10 : 2'b01;
    assign victim_oh = victim  ? 2'b10 : 2'b01;

    assign unused_addr_bits = ^{mem_address_i[31:IDX_MSB+1], mem_address_i[IDX_LSB-1:0]};

    // State and LRU registers; reset abandons any pmem transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            lru_q   <= lru_d;
        end
    end

    // Next-state, LRU update and strobe decode.
    always_comb begin
        state_d         = state_q;
        lru_d           = lru_q;
        mem_resp_o      = 1'b0;
        pmem_read_o     = 1'b0;
        pmem_write_o    = 1'b0;
        pmem_addr_sel_o = 1'b0;
        way_sel_o       = 1'b0;
        data_src_o      = 1'b0;
        load_data_o     = 2'b00;
        load_tag_o      = 2'b00;
        load_valid_o    = 2'b00;
        set_dirty_o     = 2'b00;
        clr_dirty_o     = 2'b00;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit_i != 2'b00) begin
                    mem_resp_o = 1'b1;
                    way_sel_o  = hit_way;
                    lru_d[idx] = ~hit_way;
                    if (is_write) begin
                        load_data_o = hit_oh;
                        set_dirty_o = hit_oh;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = dirty_i[victim] ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                pmem_write_o    = 1'b1;
                pmem_addr_sel_o = 1'b1;
                way_sel_o       = victim;
                if (pmem_resp_i) begin
                    state_d = FILL;
                end
            end

            FILL: begin
                pmem_read_o = 1'b1;
                way_sel_o   = victim;
                // Line lands in the victim way; COMPARE re-checks and then hits.
                if (pmem_resp_i) begin
                    data_src_o   = 1'b1;
                    load_data_o  = victim_oh;
                    load_tag_o   = victim_oh;
                    load_valid_o = victim_oh;
                    clr_dirty_o  = victim_oh;
                    state_d      = COMPARE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
